// File: rtl/inst_seq_mem.sv
// Instruction sequencer: loads a program into a small memory while idle,
// then replays it (optionally several passes) with stall support.
module inst_seq_mem #(
    parameter int INST_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int LOOP_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid,
    input  logic [INST_WIDTH-1:0]   inst_in,
    input  logic                    clear,
    input  logic                    start,
    input  logic [LOOP_W-1:0]       loop_cnt,
    input  logic                    stall,
    output logic [INST_WIDTH-1:0]   inst_out,
    output logic                    inst_valid,
    output logic                    last,
    output logic                    done,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  prog_len,
    output logic                    overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                r_state;
    logic [AW:0]           r_progLen;
    logic                  r_overflow;
    logic [AW-1:0]         r_rdPtr;
    logic [LOOP_W-1:0]     r_pass;
    logic [LOOP_W-1:0]     r_loopCnt;
    logic [INST_WIDTH-1:0] r_instOut;
    logic                  r_instValid;
    logic                  r_last;
    logic                  r_done;
    logic [INST_WIDTH-1:0] r_mem [DEPTH];

    state_t                w_stateNext;
    logic [AW:0]           w_progLenNext;
    logic                  w_overflowNext;
    logic [AW-1:0]         w_rdPtrNext;
    logic [LOOP_W-1:0]     w_passNext;
    logic [LOOP_W-1:0]     w_loopCntNext;
    logic [INST_WIDTH-1:0] w_instOutNext;
    logic                  w_instValidNext;
    logic                  w_lastNext;
    logic                  w_doneNext;
    logic                  w_memWe;
    logic                  w_lastSlot;

    assign w_lastSlot = ({1'b0, r_rdPtr} + (AW+1)'(1)) == r_progLen;

    // done trails the final issue by one cycle, so it simply follows last
    always_comb begin
        w_stateNext     = r_state;
        w_progLenNext   = r_progLen;
        w_overflowNext  = r_overflow;
        w_rdPtrNext     = r_rdPtr;
        w_passNext      = r_pass;
        w_loopCntNext   = r_loopCnt;
        w_instOutNext   = r_instOut;
        w_instValidNext = 1'b0;
        w_lastNext      = 1'b0;
        w_doneNext      = r_last;
        w_memWe         = 1'b0;
        case (r_state)
            IDLE: begin
                if (clear) begin
                    w_progLenNext  = '0;
                    w_overflowNext = 1'b0;
                end else if (start) begin
                    if (r_progLen != '0) begin
                        w_loopCntNext = loop_cnt;
                        w_rdPtrNext   = '0;
                        w_passNext    = '0;
                        w_stateNext   = RUN;
                    end else begin
                        w_doneNext = 1'b1;
                    end
                end else if (valid) begin
                    if (r_progLen == FULL_LEN) begin
                        w_overflowNext = 1'b1;
                    end else begin
                        w_memWe       = 1'b1;
                        w_progLenNext = r_progLen + (AW+1)'(1);
                    end
                end
            end
            RUN: begin
                if (!stall) begin
                    w_instOutNext   = r_mem[r_rdPtr];
                    w_instValidNext = 1'b1;
                    if (w_lastSlot) begin
                        w_rdPtrNext = '0;
                        if (r_pass == r_loopCnt) begin
                            w_lastNext  = 1'b1;
                            w_stateNext = IDLE;
                        end else begin
                            w_passNext = r_pass + LOOP_W'(1);
                        end
                    end else begin
                        w_rdPtrNext = r_rdPtr + AW'(1);
                    end
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_progLen   <= '0;
            r_overflow  <= 1'b0;
            r_rdPtr     <= '0;
            r_pass      <= '0;
            r_loopCnt   <= '0;
            r_instOut   <= '0;
            r_instValid <= 1'b0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_progLen   <= w_progLenNext;
            r_overflow  <= w_overflowNext;
            r_rdPtr     <= w_rdPtrNext;
            r_pass      <= w_passNext;
            r_loopCnt   <= w_loopCntNext;
            r_instOut   <= w_instOutNext;
            r_instValid <= w_instValidNext;
            r_last      <= w_lastNext;
            r_done      <= w_doneNext;
        end
    end

    // Program storage carries no reset; a cleared program is just a zero length
    always_ff @(posedge clk) begin
        if (rst && w_memWe) begin
            r_mem[r_progLen[AW-1:0]] <= inst_in;
        end
    end

    assign inst_out   = r_instOut;
    assign inst_valid = r_instValid;
    assign last       = r_last;
    assign done       = r_done;
    assign busy       = (r_state == RUN);
    assign prog_len   = r_progLen;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_inst_seq_mem.sv
// Self-checking bench for inst_seq_mem: directed scenarios plus randomized
// programs, compared against a queue-based model of the playback order.
module tb_inst_seq_mem;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [63:0] inst_in;
    logic        clear;
    logic        start;
    logic [7:0]  loop_cnt;
    logic        stall;
    logic [63:0] inst_out;
    logic        inst_valid;
    logic        last;
    logic        done;
    logic        busy;
    logic [4:0]  prog_len;
    logic        overflow;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] prog[$];
    bit          ovfModel;
    logic [63:0] modelOut;

    inst_seq_mem #(.INST_WIDTH(64), .DEPTH(DEPTH), .LOOP_W(8)) dut (
        .clk(clk), .rst(rst), .valid(valid), .inst_in(inst_in), .clear(clear),
        .start(start), .loop_cnt(loop_cnt), .stall(stall), .inst_out(inst_out),
        .inst_valid(inst_valid), .last(last), .done(done), .busy(busy),
        .prog_len(prog_len), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are sampled there too
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_out"}, inst_out, 64'd0);
        checkOutput({tag, "_valid"}, inst_valid, 1'b0);
        checkOutput({tag, "_last"}, last, 1'b0);
        checkOutput({tag, "_done"}, done, 1'b0);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_len"}, prog_len, 5'd0);
        checkOutput({tag, "_ovf"}, overflow, 1'b0);
    endtask

    task automatic resetDut();
        rst = 1'b0; valid = 1'b0; clear = 1'b0; start = 1'b0; stall = 1'b0;
        applyStimulus();
        prog = {};
        ovfModel = 1'b0;
        modelOut = 64'd0;
        checkIdleZero("reset");
        rst = 1'b1;
    endtask

    task automatic loadWord(input logic [63:0] w);
        valid = 1'b1;
        inst_in = w;
        applyStimulus();
        valid = 1'b0;
        if (prog.size() < DEPTH) prog.push_back(w);
        else ovfModel = 1'b1;
        checkOutput("loadLen", prog_len, prog.size());
        checkOutput("loadOvf", overflow, ovfModel);
    endtask

    task automatic doClear();
        clear = 1'b1;
        applyStimulus();
        clear = 1'b0;
        prog = {};
        ovfModel = 1'b0;
        checkOutput("clearLen", prog_len, 5'd0);
        checkOutput("clearOvf", overflow, 1'b0);
    endtask

    // stallMode: 0 none, 1 random, 2 three cycles before issue number stallAt
    task automatic playProgram(input logic [7:0] loops, input int stallMode, input int stallAt, input bit disturb);
        logic [63:0] expq[$];
        int idx;
        int budget;
        int stallLeft;
        bit stallNow;
        expq = {};
        for (int p = 0; p <= int'(loops); p++)
            foreach (prog[i]) expq.push_back(prog[i]);
        start = 1'b1;
        loop_cnt = loops;
        applyStimulus();
        start = 1'b0;
        valid = 1'b0;
        checkOutput("startBusy", busy, 1'b1);
        checkOutput("startNoIssue", inst_valid, 1'b0);
        idx = 0;
        budget = 0;
        stallLeft = 3;
        while (idx < expq.size() && budget < 4000) begin
            stallNow = 1'b0;
            if (stallMode == 1) stallNow = ($urandom_range(0, 3) == 0);
            else if (stallMode == 2 && idx == stallAt && stallLeft > 0) begin
                stallNow = 1'b1;
                stallLeft--;
            end
            stall = stallNow;
            if (disturb) begin
                valid = 1'($urandom_range(0, 1));
                clear = 1'($urandom_range(0, 1));
                start = 1'($urandom_range(0, 1));
                inst_in = {$urandom, $urandom};
            end
            applyStimulus();
            budget++;
            if (stallNow) begin
                checkOutput("stallValid", inst_valid, 1'b0);
                checkOutput("stallHold", inst_out, modelOut);
                checkOutput("stallLast", last, 1'b0);
            end else begin
                checkOutput("issueValid", inst_valid, 1'b1);
                checkOutput("issueWord", inst_out, expq[idx]);
                checkOutput("issueLast", last, idx == expq.size() - 1);
                modelOut = expq[idx];
                idx++;
            end
            checkOutput("runDone", done, 1'b0);
            checkOutput("runBusy", busy, idx < expq.size());
        end
        stall = 1'b0; valid = 1'b0; clear = 1'b0; start = 1'b0;
        checkOutput("issueCount", idx, expq.size());
        applyStimulus();
        checkOutput("donePulse", done, 1'b1);
        checkOutput("doneNoIssue", inst_valid, 1'b0);
        checkOutput("doneLast", last, 1'b0);
        checkOutput("doneBusy", busy, 1'b0);
        checkOutput("idleHold", inst_out, modelOut);
        applyStimulus();
        checkOutput("doneOnce", done, 1'b0);
        checkOutput("progKept", prog_len, prog.size());
        checkOutput("ovfKept", overflow, ovfModel);
    endtask

    task automatic emptyStart();
        start = 1'b1;
        loop_cnt = 8'd3;
        applyStimulus();
        start = 1'b0;
        checkOutput("emptyBusy", busy, 1'b0);
        checkOutput("emptyValid", inst_valid, 1'b0);
        checkOutput("emptyDone", done, 1'b1);
        applyStimulus();
        checkOutput("emptyDoneOnce", done, 1'b0);
        checkOutput("emptyValid2", inst_valid, 1'b0);
        checkOutput("emptyBusy2", busy, 1'b0);
    endtask

    initial begin
        rst = 1'b0; valid = 1'b0; clear = 1'b0; start = 1'b0; stall = 1'b0;
        inst_in = 64'd0; loop_cnt = 8'd0;
        resetDut();

        loadWord(64'h00000000ffff0000);
        loadWord(64'h00000000ffffaaaa);
        loadWord(64'h00000000ffffbbbb);
        loadWord(64'h00000000ffffcccc);
        loadWord(64'h00000000ffffdddd);
        playProgram(8'd0, 0, 0, 1'b0);
        playProgram(8'd2, 2, 7, 1'b0);

        // start and valid together: the write must be dropped
        valid = 1'b1;
        inst_in = 64'hdeadbeefdeadbeef;
        playProgram(8'd1, 1, 0, 1'b0);
        playProgram(8'd1, 1, 0, 1'b1);

        doClear();
        for (int i = 0; i < DEPTH + 1; i++) loadWord({$urandom, $urandom});
        checkOutput("fullLen", prog_len, 5'd16);
        checkOutput("fullOvf", overflow, 1'b1);
        playProgram(8'd0, 0, 0, 1'b0);
        doClear();
        emptyStart();

        for (int i = 0; i < 5; i++) loadWord({$urandom, $urandom});
        start = 1'b1;
        loop_cnt = 8'd3;
        applyStimulus();
        start = 1'b0;
        applyStimulus();
        checkOutput("preResetIssue1", inst_out, prog[0]);
        applyStimulus();
        checkOutput("preResetIssue2", inst_out, prog[1]);
        resetDut();
        emptyStart();

        for (int r = 0; r < 6; r++) begin
            int len;
            doClear();
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) loadWord({$urandom, $urandom});
            playProgram(8'($urandom_range(0, 3)), 1, 0, 1'(r % 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
